// File: rtl/cu_fsm_seq.sv
// Multi-cycle control-unit FSM: INIT, FETCH, EXEC, WB, optional INTR.
// Optional interrupt support is enabled by defining CU_FSM_INTR_EN.
//
// Ports:
//   CLK, CU_FSM_RST_N      rising-edge clock, async active-low reset
//   CU_FSM_OPCODE[6:0]     ir[6:0] of the current instruction
//   CU_FSM_FUNC3[2:0]      ir[14:12]
//   CU_FSM_MEM_READY       memory read data valid this cycle
//   CU_FSM_INTR, _MIE      interrupt request (level) and CSR enable
//   CU_FSM_PC_RST ..       1-bit control strobes, decoded combinationally
//   CU_FSM_STATE[2:0]      state code (INIT=0 FETCH=1 EXEC=2 WB=3 INTR=4)
//   CU_FSM_INSTRET[31:0]   retired-instruction counter
`timescale 1ns/1ps

module cu_fsm_seq (
  input  logic        CLK,
  input  logic        CU_FSM_RST_N,
  input  logic [6:0]  CU_FSM_OPCODE,
  input  logic [2:0]  CU_FSM_FUNC3,
  input  logic        CU_FSM_MEM_READY,
  input  logic        CU_FSM_INTR,
  input  logic        CU_FSM_MIE,
  output logic        CU_FSM_PC_RST,
  output logic        CU_FSM_PC_WRITE,
  output logic        CU_FSM_REG_WRITE,
  output logic        CU_FSM_MEM_RDEN1,
  output logic        CU_FSM_MEM_RDEN2,
  output logic        CU_FSM_MEM_WE2,
  output logic        CU_FSM_CSR_WE,
  output logic        CU_FSM_INT_TAKEN,
  output logic [2:0]  CU_FSM_STATE,
  output logic [31:0] CU_FSM_INSTRET
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      r_state;
  state_t      w_next;
  state_t      w_ret_next;
  logic [31:0] r_instret;
  logic        w_retire;

  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_system;
  logic w_f3_nz;

  assign w_is_load   = (CU_FSM_OPCODE == OP_LOAD);
  assign w_is_store  = (CU_FSM_OPCODE == OP_STORE);
  assign w_is_branch = (CU_FSM_OPCODE == OP_BRANCH);
  assign w_is_system = (CU_FSM_OPCODE == OP_SYSTEM);
  assign w_f3_nz     = (CU_FSM_FUNC3 != 3'b000);

`ifdef CU_FSM_INTR_EN
  logic r_pending;

  // Leaving INTR clears the request even if INTR is still high.
  always_ff @(posedge CLK or negedge CU_FSM_RST_N) begin
    if (!CU_FSM_RST_N) begin
      r_pending <= 1'b0;
    end else if (r_state == S_INTR) begin
      r_pending <= 1'b0;
    end else if (CU_FSM_INTR) begin
      r_pending <= 1'b1;
    end
  end

  assign w_ret_next = (r_pending && CU_FSM_MIE)
                    ? S_INTR : S_FETCH;
`else
  logic w_unused;
  assign w_unused   = ^{CU_FSM_INTR, CU_FSM_MIE};
  assign w_ret_next = S_FETCH;
`endif

  always_ff @(posedge CLK or negedge CU_FSM_RST_N) begin
    if (!CU_FSM_RST_N) begin
      r_state   <= S_INIT;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  always_comb begin
    w_next           = S_INIT;
    w_retire         = 1'b0;
    CU_FSM_PC_RST    = 1'b0;
    CU_FSM_PC_WRITE  = 1'b0;
    CU_FSM_REG_WRITE = 1'b0;
    CU_FSM_MEM_RDEN1 = 1'b0;
    CU_FSM_MEM_RDEN2 = 1'b0;
    CU_FSM_MEM_WE2   = 1'b0;
    CU_FSM_CSR_WE    = 1'b0;
    CU_FSM_INT_TAKEN = 1'b0;
    unique case (r_state)
      S_INIT: begin
        CU_FSM_PC_RST = 1'b1;
        w_next        = S_FETCH;
      end
      S_FETCH: begin
        CU_FSM_MEM_RDEN1 = 1'b1;
        w_next = CU_FSM_MEM_READY ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        w_next = w_ret_next;
        unique case (1'b1)
          w_is_load: begin
            CU_FSM_MEM_RDEN2 = 1'b1;
            w_next           = S_WB;
          end
          w_is_store: begin
            CU_FSM_MEM_WE2  = 1'b1;
            CU_FSM_PC_WRITE = 1'b1;
            w_retire        = 1'b1;
          end
          w_is_branch: begin
            CU_FSM_PC_WRITE = 1'b1;
            w_retire        = 1'b1;
          end
          w_is_system: begin
            CU_FSM_PC_WRITE  = 1'b1;
            CU_FSM_CSR_WE    = w_f3_nz;
            CU_FSM_REG_WRITE = w_f3_nz;
            w_retire         = 1'b1;
          end
          default: begin
            CU_FSM_PC_WRITE  = 1'b1;
            CU_FSM_REG_WRITE = 1'b1;
            w_retire         = 1'b1;
          end
        endcase
      end
      S_WB: begin
        w_next = S_WB;
        if (CU_FSM_MEM_READY) begin
          CU_FSM_REG_WRITE = 1'b1;
          CU_FSM_PC_WRITE  = 1'b1;
          w_retire         = 1'b1;
          w_next           = w_ret_next;
        end
      end
`ifdef CU_FSM_INTR_EN
      S_INTR: begin
        CU_FSM_INT_TAKEN = 1'b1;
        CU_FSM_PC_WRITE  = 1'b1;
        w_next           = S_FETCH;
      end
`endif
      default: begin
        w_next = S_INIT;
      end
    endcase
  end

  assign CU_FSM_STATE   = r_state;
  assign CU_FSM_INSTRET = r_instret;

endmodule

// File: tb/tb_cu_fsm_seq.sv
// Scoreboard bench for cu_fsm_seq: instruction-level model pushes the
// expected per-cycle outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_cu_fsm_seq;

`ifdef CU_FSM_INTR_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  localparam logic [7:0] O_RST = 8'h80;
  localparam logic [7:0] O_PCW = 8'h40;
  localparam logic [7:0] O_RW  = 8'h20;
  localparam logic [7:0] O_RD1 = 8'h10;
  localparam logic [7:0] O_RD2 = 8'h08;
  localparam logic [7:0] O_WE2 = 8'h04;
  localparam logic [7:0] O_CSR = 8'h02;
  localparam logic [7:0] O_INT = 8'h01;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] ALU    = 7'b0110011;

  logic        CLK;
  logic        CU_FSM_RST_N;
  logic [6:0]  CU_FSM_OPCODE;
  logic [2:0]  CU_FSM_FUNC3;
  logic        CU_FSM_MEM_READY;
  logic        CU_FSM_INTR;
  logic        CU_FSM_MIE;
  logic        CU_FSM_PC_RST;
  logic        CU_FSM_PC_WRITE;
  logic        CU_FSM_REG_WRITE;
  logic        CU_FSM_MEM_RDEN1;
  logic        CU_FSM_MEM_RDEN2;
  logic        CU_FSM_MEM_WE2;
  logic        CU_FSM_CSR_WE;
  logic        CU_FSM_INT_TAKEN;
  logic [2:0]  CU_FSM_STATE;
  logic [31:0] CU_FSM_INSTRET;

  cu_fsm_seq dut (
    .CLK              (CLK),
    .CU_FSM_RST_N     (CU_FSM_RST_N),
    .CU_FSM_OPCODE    (CU_FSM_OPCODE),
    .CU_FSM_FUNC3     (CU_FSM_FUNC3),
    .CU_FSM_MEM_READY (CU_FSM_MEM_READY),
    .CU_FSM_INTR      (CU_FSM_INTR),
    .CU_FSM_MIE       (CU_FSM_MIE),
    .CU_FSM_PC_RST    (CU_FSM_PC_RST),
    .CU_FSM_PC_WRITE  (CU_FSM_PC_WRITE),
    .CU_FSM_REG_WRITE (CU_FSM_REG_WRITE),
    .CU_FSM_MEM_RDEN1 (CU_FSM_MEM_RDEN1),
    .CU_FSM_MEM_RDEN2 (CU_FSM_MEM_RDEN2),
    .CU_FSM_MEM_WE2   (CU_FSM_MEM_WE2),
    .CU_FSM_CSR_WE    (CU_FSM_CSR_WE),
    .CU_FSM_INT_TAKEN (CU_FSM_INT_TAKEN),
    .CU_FSM_STATE     (CU_FSM_STATE),
    .CU_FSM_INSTRET   (CU_FSM_INSTRET)
  );

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [7:0]  o;
    logic [31:0] ir;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_instret = 32'd0;
  bit          m_pend = 1'b0;
  bit          m_mie  = 1'b0;

  logic [7:0] w_outs;
  assign w_outs = {CU_FSM_PC_RST, CU_FSM_PC_WRITE,
                   CU_FSM_REG_WRITE, CU_FSM_MEM_RDEN1,
                   CU_FSM_MEM_RDEN2, CU_FSM_MEM_WE2,
                   CU_FSM_CSR_WE, CU_FSM_INT_TAKEN};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (CU_FSM_STATE !== e.st || w_outs !== e.o ||
            CU_FSM_INSTRET !== e.ir) begin
          n_fail++;
          $display("FAIL %s @%0t: got st=%0d out=%b ir=%h, want st=%0d out=%b ir=%h",
                   e.tag, $time, CU_FSM_STATE, w_outs,
                   CU_FSM_INSTRET, e.st, e.o, e.ir);
        end
        n_chk++;
        if ($countones({CU_FSM_MEM_RDEN1, CU_FSM_MEM_RDEN2,
                        CU_FSM_MEM_WE2}) > 1) begin
          n_fail++;
          $display("FAIL mem_onehot @%0t: got %b, want at most one",
                   $time, w_outs[4:2]);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  function automatic logic [7:0] exec_out(input logic [6:0] op,
                                          input logic [2:0] f3);
    case (op)
      LOAD:    return O_RD2;
      STORE:   return O_WE2 | O_PCW;
      BRANCH:  return O_PCW;
      SYSTEM:  return (f3 != 3'd0) ? (O_PCW | O_CSR | O_RW) : O_PCW;
      default: return O_PCW | O_RW;
    endcase
  endfunction

  // One clock cycle: drive inputs just after the edge, record expectation.
  task automatic cyc(input string tag, input logic [2:0] st,
                     input logic [7:0] o, input logic rdy,
                     input logic irq);
    exp_t e;
    @(posedge CLK);
    #1;
    CU_FSM_MEM_READY = rdy;
    CU_FSM_INTR      = irq;
    CU_FSM_MIE       = m_mie;
    e.tag = tag;
    e.st  = st;
    e.o   = o;
    e.ir  = m_instret;
    q.push_back(e);
  endtask

  task automatic retire(output bit take);
    take      = EN && m_pend && m_mie;
    m_instret = m_instret + 32'd1;
  endtask

  // One whole instruction at transaction level; intr_at picks the cycle
  // (counted from the first fetch cycle) in which INTR is pulsed.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input int nfw, input int nwb,
                           input int intr_at);
    int  k = 0;
    bit  take = 1'b0;
    bit  irq;
    bit  rdy;
    for (int i = 0; i <= nfw; i++) begin
      irq = (k == intr_at);
      cyc("fetch", 3'd1, O_RD1, i == nfw, irq);
      if (i == 0) begin
        CU_FSM_OPCODE = op;
        CU_FSM_FUNC3  = f3;
      end
      if (irq && EN) m_pend = 1'b1;
      k++;
    end
    irq = (k == intr_at);
    cyc("exec", 3'd2, exec_out(op, f3), 1'b0, irq);
    if (op != LOAD) retire(take);
    if (irq && EN) m_pend = 1'b1;
    k++;
    if (op == LOAD) begin
      for (int j = 0; j <= nwb; j++) begin
        irq = (k == intr_at);
        rdy = (j == nwb);
        cyc("wb", 3'd3, rdy ? (O_PCW | O_RW) : 8'h00, rdy, irq);
        if (rdy) retire(take);
        if (irq && EN) m_pend = 1'b1;
        k++;
      end
    end
    if (take) begin
      irq = (k == intr_at);
      cyc("intr", 3'd4, O_INT | O_PCW, 1'b0, irq);
      m_pend = 1'b0;
    end
  endtask

  task automatic rel_reset();
    exp_t e;
    @(posedge CLK);
    #1;
    CU_FSM_RST_N     = 1'b1;
    CU_FSM_MEM_READY = 1'b0;
    CU_FSM_INTR      = 1'b0;
    m_instret = 32'd0;
    m_pend    = 1'b0;
    e.tag = "init";
    e.st  = 3'd0;
    e.o   = O_RST;
    e.ir  = 32'd0;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    CU_FSM_RST_N     = 1'b0;
    CU_FSM_OPCODE    = 7'd0;
    CU_FSM_FUNC3     = 3'd0;
    CU_FSM_MEM_READY = 1'b0;
    CU_FSM_INTR      = 1'b0;
    CU_FSM_MIE       = 1'b0;
    #3;
    chk("rst_state", 64'(CU_FSM_STATE), 64'd0);
    chk("rst_outs", 64'(w_outs), 64'(O_RST));
    chk("rst_instret", 64'(CU_FSM_INSTRET), 64'd0);
    rel_reset();

    // ALU op, fetch ready at once: 0,1,2,1 and INSTRET=1
    run_instr(ALU, 3'd0, 0, 0, -1);
    // LOAD with WB held three cycles
    run_instr(LOAD, 3'd2, 1, 3, -1);
    run_instr(STORE, 3'd1, 0, 0, -1);
    run_instr(BRANCH, 3'd0, 2, 0, -1);
    run_instr(SYSTEM, 3'd0, 0, 0, -1);
    run_instr(SYSTEM, 3'd5, 0, 0, -1);

    // interrupt pulsed in fetch with MIE=1
    m_mie = 1'b1;
    run_instr(ALU, 3'd0, 1, 0, 0);
    run_instr(ALU, 3'd0, 0, 0, -1);

    // pulse held off by MIE=0 for five instructions
    m_mie = 1'b0;
    run_instr(ALU, 3'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_instr(STORE, 3'd0, 0, 0, -1);
    m_mie = 1'b1;
    run_instr(BRANCH, 3'd0, 0, 0, -1);
    run_instr(ALU, 3'd0, 0, 0, -1);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      int sel;
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = LOAD;
        1: op = STORE;
        2: op = BRANCH;
        3: op = SYSTEM;
        4: op = ALU;
        5: op = 7'b0010011;
        default: op = 7'($urandom);
      endcase
      m_mie = 1'($urandom);
      run_instr(op, 3'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 12));
    end

    // counter wrap: preload all-ones while in FETCH
    m_mie = 1'b0;
    run_instr(ALU, 3'd0, 0, 0, -1);
    @(posedge CLK);
    #1;
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    CU_FSM_MEM_READY = 1'b0;
    CU_FSM_INTR      = 1'b0;
    CU_FSM_MIE       = m_mie;
    m_instret = 32'hFFFF_FFFF;
    e.tag = "wrap_fetch";
    e.st  = 3'd1;
    e.o   = O_RD1;
    e.ir  = m_instret;
    q.push_back(e);
    run_instr(ALU, 3'd0, 0, 0, -1);
    run_instr(BRANCH, 3'd0, 0, 0, -1);
    chk("wrap_model", 64'(m_instret), 64'd1);

    // reset pulsed mid-WB of a LOAD
    CU_FSM_INTR = 1'b0;
    cyc("fetch", 3'd1, O_RD1, 1'b1, 1'b0);
    CU_FSM_OPCODE = LOAD;
    cyc("exec", 3'd2, O_RD2, 1'b0, 1'b0);
    cyc("wb", 3'd3, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    #2;
    CU_FSM_RST_N = 1'b0;
    #1;
    chk("async_state", 64'(CU_FSM_STATE), 64'd0);
    chk("async_instret", 64'(CU_FSM_INSTRET), 64'd0);
    chk("async_outs", 64'(w_outs), 64'(O_RST));
    CU_FSM_MEM_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_hold_outs", 64'(w_outs), 64'(O_RST));
    chk("rst_hold_state", 64'(CU_FSM_STATE), 64'd0);
    rel_reset();
    run_instr(ALU, 3'd0, 0, 0, -1);
    run_instr(LOAD, 3'd0, 0, 1, -1);

    repeat (3) @(negedge CLK);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
